// File: rtl/lock_pkg.sv
// Shared state/direction types and default timing for the lock_sequencer airlock.
// The wait-state watchdog default is only consumed when LOCK_TIMEOUT_EN is defined.
package lock_pkg;
  localparam int CNT_W           = 16;
  localparam int FILL_CYC_DEF    = 8;
  localparam int DOOR_CYC_DEF    = 4;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FILL      = 4'd1,
    OPEN_OUT  = 4'd2,
    WAIT_OUT  = 4'd3,
    CLOSE_OUT = 4'd4,
    DRAIN     = 4'd5,
    OPEN_IN   = 4'd6,
    WAIT_IN   = 4'd7,
    CLOSE_IN  = 4'd8
  } lock_state_t;

  typedef enum logic {
    ARR = 1'b0,
    DEP = 1'b1
  } lock_dir_t;

  function automatic logic is_timed(input lock_state_t s);
    return (s == FILL) || (s == DRAIN) || (s == OPEN_OUT) || (s == CLOSE_OUT) ||
           (s == OPEN_IN) || (s == CLOSE_IN);
  endfunction
endpackage

// File: rtl/lock_sequencer_if.sv
// Request/grant handshake and chamber command bundle of the lock sequencer.
// The sequencer takes the slave side; the chamber environment drives the master side.
interface lock_sequencer_if;
  logic arrive_req;
  logic depart_req;
  logic sub_present;
  logic fill;
  logic empty;
  logic outer_open;
  logic inner_open;
  logic grant_arr;
  logic grant_dep;
  logic busy;
  logic flooded;
  logic aborted;

  modport slave (
    input  arrive_req, depart_req, sub_present,
    output fill, empty, outer_open, inner_open, grant_arr, grant_dep, busy, flooded, aborted
  );

  modport master (
    output arrive_req, depart_req, sub_present,
    input  fill, empty, outer_open, inner_open, grant_arr, grant_dep, busy, flooded, aborted
  );
endinterface

// File: rtl/lock_timer.sv
// Shared down-counter for the timed lock states: loaded on state entry, done at zero.
module lock_timer
  import lock_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == {CNT_W{1'b0}});
endmodule

// File: rtl/lock_sequencer.sv
// Airlock sequencer: arbitrates arrival/departure requests and steps the chamber through fill,
// door and drain phases. Optional wait-state watchdog enabled by defining LOCK_TIMEOUT_EN.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int FILL_CYC = FILL_CYC_DEF,
  parameter int DOOR_CYC = DOOR_CYC_DEF
`ifdef LOCK_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input logic             clk,
  input logic             rst,
  lock_sequencer_if.slave bus
);
  lock_state_t      state_q, state_d;
  lock_dir_t        dir_q, dir_d, last_dir_q, last_dir_d;
  logic             pend_arr_q, pend_arr_d, pend_dep_q, pend_dep_d;
  logic             flooded_q, flooded_d;
  logic             grant_arr_s, grant_dep_s, abort_s, wait_to_s;
  logic             out_exit_s, in_exit_s;
  logic             tmr_load_s, tmr_done_s;
  logic [CNT_W-1:0] tmr_value_s;

`ifdef LOCK_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Cycles spent in the current wait state; restarts on every wait entry.
  always_comb begin
    if ((state_d == WAIT_OUT || state_d == WAIT_IN) && (state_d == state_q)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= {CNT_W{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_to_s = (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign wait_to_s = 1'b0;
`endif

  // Next-state, arbitration and grant decode.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    last_dir_d  = last_dir_q;
    flooded_d   = flooded_q;
    grant_arr_s = 1'b0;
    grant_dep_s = 1'b0;
    abort_s     = 1'b0;
    out_exit_s  = (bus.sub_present == (dir_q == ARR));
    in_exit_s   = (bus.sub_present == (dir_q == DEP));
    case (state_q)
      IDLE: begin
        if (pend_arr_q && (!pend_dep_q || last_dir_q == DEP)) begin
          grant_arr_s = 1'b1;
          dir_d       = ARR;
          last_dir_d  = ARR;
          state_d     = FILL;
        end else if (pend_dep_q) begin
          grant_dep_s = 1'b1;
          dir_d       = DEP;
          last_dir_d  = DEP;
          state_d     = OPEN_IN;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (tmr_done_s) begin
          state_d   = OPEN_OUT;
          flooded_d = 1'b1;
        end else begin
          state_d = FILL;
        end
      end
      OPEN_OUT:  state_d = tmr_done_s ? WAIT_OUT : OPEN_OUT;
      // An abort rewrites dir so the normal paths lead straight back to a dry IDLE.
      WAIT_OUT: begin
        if (out_exit_s) begin
          state_d = CLOSE_OUT;
        end else if (wait_to_s) begin
          state_d = CLOSE_OUT;
          dir_d   = DEP;
          abort_s = 1'b1;
        end else begin
          state_d = WAIT_OUT;
        end
      end
      CLOSE_OUT: state_d = tmr_done_s ? DRAIN : CLOSE_OUT;
      DRAIN: begin
        if (tmr_done_s) begin
          flooded_d = 1'b0;
          state_d   = (dir_q == ARR) ? OPEN_IN : IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      OPEN_IN:   state_d = tmr_done_s ? WAIT_IN : OPEN_IN;
      WAIT_IN: begin
        if (in_exit_s) begin
          state_d = CLOSE_IN;
        end else if (wait_to_s) begin
          state_d = CLOSE_IN;
          dir_d   = ARR;
          abort_s = 1'b1;
        end else begin
          state_d = WAIT_IN;
        end
      end
      CLOSE_IN: begin
        if (tmr_done_s) begin
          state_d = (dir_q == ARR) ? IDLE : FILL;
        end else begin
          state_d = CLOSE_IN;
        end
      end
      default: state_d = IDLE;
    endcase
    pend_arr_d = (pend_arr_q | bus.arrive_req) & ~grant_arr_s;
    pend_dep_d = (pend_dep_q | bus.depart_req) & ~grant_dep_s;
  end

  // Reload the shared timer whenever a timed state is entered.
  always_comb begin
    tmr_load_s = (state_d != state_q) && is_timed(state_d);
    if (state_d == FILL || state_d == DRAIN) begin
      tmr_value_s = CNT_W'(FILL_CYC - 1);
    end else begin
      tmr_value_s = CNT_W'(DOOR_CYC - 1);
    end
  end

  lock_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load_s),
    .value (tmr_value_s),
    .done  (tmr_done_s)
  );

  // FSM, direction, pending and chamber-level registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dir_q      <= DEP;
      last_dir_q <= DEP;
      pend_arr_q <= 1'b0;
      pend_dep_q <= 1'b0;
      flooded_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      pend_arr_q <= pend_arr_d;
      pend_dep_q <= pend_dep_d;
      flooded_q  <= flooded_d;
    end
  end

  // Commands decode from the state register so reset closes doors and stops pumps at once.
  assign bus.fill       = (state_q == FILL);
  assign bus.empty      = (state_q == DRAIN);
  assign bus.outer_open = (state_q == OPEN_OUT) || (state_q == WAIT_OUT);
  assign bus.inner_open = (state_q == OPEN_IN) || (state_q == WAIT_IN);
  assign bus.grant_arr  = grant_arr_s;
  assign bus.grant_dep  = grant_dep_s;
  assign bus.busy       = (state_q != IDLE);
  assign bus.flooded    = flooded_q;
  // Without the watchdog abort_s is constant zero, so aborted is tied low.
  assign bus.aborted    = abort_s;
endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameter FILL_CYC, 8, cycles spent in FILL or DRAIN.
REQ-002 Parameter DOOR_CYC, 4, cycles spent in any door open or close state.
REQ-003 Parameter TIMEOUT_CYC, 64, wait-state watchdog limit; used only with LOCK_TIMEOUT_EN.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, reset, asynchronous and active-low.
REQ-006 Port arrive_req, input, 1, one-cycle pulse: a bathysphere at the outer (ocean) side requests entry.
REQ-007 Port depart_req, input, 1, one-cycle pulse: a bathysphere at the inner side requests exit.
REQ-008 Port sub_present, input, 1, level: bathysphere is inside the chamber.
REQ-009 Port fill, output, 1, flood command to the chamber.
REQ-010 Port empty, output, 1, drain command to the chamber.
REQ-011 Port outer_open, output, 1, outer door command (1 = open).
REQ-012 Port inner_open, output, 1, inner door command (1 = open).
REQ-013 Port grant_arr, output, 1, one-cycle pulse: arrival transaction started.
REQ-014 Port grant_dep, output, 1, one-cycle pulse: departure transaction started.
REQ-015 Port busy, output, 1, high in every state except IDLE.
REQ-016 Port flooded, output, 1, registered chamber-level flag.
REQ-017 Port aborted, output, 1, one-cycle pulse when a watchdog abort occurs.

Function
REQ-018 The FSM states SHALL be IDLE, FILL, OPEN_OUT, WAIT_OUT, CLOSE_OUT, DRAIN, OPEN_IN, WAIT_IN, CLOSE_IN, with a direction register dir (ARR or DEP).
REQ-019 Arrival path: IDLE->FILL->OPEN_OUT->WAIT_OUT (exit when sub_present=1)->CLOSE_OUT->DRAIN->OPEN_IN->WAIT_IN (exit when sub_present=0)->CLOSE_IN->IDLE.
REQ-020 Departure path: IDLE->OPEN_IN->WAIT_IN (exit when sub_present=1)->CLOSE_IN->FILL->OPEN_OUT->WAIT_OUT (exit when sub_present=0)->CLOSE_OUT->DRAIN->IDLE.
REQ-021 Timed states: FILL and DRAIN last exactly FILL_CYC cycles; OPEN_* and CLOSE_* last exactly DOOR_CYC cycles. A single 16-bit down-counter is loaded on state entry.
REQ-022 Wait states have no minimum duration; the exit is taken on the first cycle the sub_present condition holds.
REQ-023 Outputs are decoded from registered state: fill only in FILL; empty only in DRAIN; outer_open in OPEN_OUT and WAIT_OUT; inner_open in OPEN_IN and WAIT_IN.
REQ-024 Interlock: outer_open and inner_open never both 1; outer_open=1 only when flooded=1; inner_open=1 only when flooded=0.
REQ-025 flooded sets on the FILL->OPEN_OUT transition and clears on the DRAIN exit.
REQ-026 arrive_req and depart_req pulses set sticky pending bits, and a pending bit clears in the cycle its grant pulses.
REQ-027 A request arriving while busy stays pending. A duplicate pulse while already pending is absorbed.
REQ-028 Arbitration in IDLE:
- Only one request pending: that request is served.
- Both pending: serve the direction opposite to last_dir.
- last_dir resets to DEP, so arrival wins the first tie.
REQ-029 The grant pulse is asserted in the IDLE cycle that the transition is taken; busy rises in the next cycle.

Reset
REQ-030 While rst=0 the block SHALL be in IDLE with all of the following cleared:
- counter=0, pending bits=0, flooded=0, last_dir=DEP.
- fill, empty, outer_open, inner_open, grant_arr, grant_dep, busy and aborted all 0.
REQ-031 Reset asserted mid-transaction SHALL close both doors immediately (combinationally via state) and stop pumping. Recovery is by external procedure; the block assumes a dry chamber after reset.

Configuration
REQ-032 With LOCK_TIMEOUT_EN defined, a wait-state counter runs as follows:
- In WAIT_OUT or WAIT_IN, if the exit condition has not held for TIMEOUT_CYC cycles, pulse aborted.
- From WAIT_OUT, go to CLOSE_OUT->DRAIN->IDLE.
- From WAIT_IN, go to CLOSE_IN->IDLE, or CLOSE_IN->FILL->... if flooded=1 is impossible there, so CLOSE_IN->IDLE.
REQ-033 Without LOCK_TIMEOUT_EN:
- Wait states wait indefinitely.
- aborted is tied to 0.
- No timeout counter logic exists.

Structure
REQ-034 A shared package lock_pkg SHALL hold:
- The state enumeration and the dir encoding (ARR=0, DEP=1).
- The default timing constants.
REQ-035 The down-counter SHALL be a sub-module lock_timer, with inputs load and value and output done, and one instance of it.

Verification
REQ-036 Arrival, defaults: arrive_req pulse then sub_present=1 at the first WAIT_OUT cycle -> grant_arr 1 cycle, fill 8 cycles, outer_open 4+N cycles, empty 8 cycles, back in IDLE with flooded=0.
REQ-037 Departure: depart_req pulse -> inner_open first; after sub_present rises then falls, the order is fill, outer, drain; busy total = 4+W1+4+8+4+W2+4+8 cycles.
REQ-038 Tie: arrive_req and depart_req in the same cycle -> arrival served first, departure granted on the first IDLE cycle after it; a second tie then grants arrival.
REQ-039 Pulse while busy: depart_req during DRAIN of an arrival -> held pending, granted immediately after CLOSE_IN->IDLE.
REQ-040 Interlock assertion checked every cycle across randomized sub_present: never outer_open&inner_open, never outer_open&~flooded.
REQ-041 With LOCK_TIMEOUT_EN, hold sub_present=0 in WAIT_OUT -> aborted after 64 cycles, outer closes, chamber drains, IDLE with flooded=0. Assert rst mid-FILL -> all outputs 0 asynchronously.
